// File: rtl/sp_sweep_sequencer_pkg.sv
// sp_seq_pkg: shared state encoding, port constants and result record for the sweep sequencer
package sp_seq_pkg;
  localparam int RES_IDX_W  = 8;
  localparam int RES_DATA_W = 16;
  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;
  typedef enum logic [3:0] {
    S_IDLE, S_DC_SETTLE, S_DC_MEAS, S_SET_SRC, S_SETTLE, S_MEAS, S_EMIT, S_NEXT, S_FIN
  } state_t;
  typedef struct packed {
    logic [RES_IDX_W-1:0]  idx;
    logic                  port;
    logic [RES_DATA_W-1:0] a;
    logic [RES_DATA_W-1:0] b;
  } result_t;
endpackage

// File: rtl/sp_settle_timer.sv
// sp_settle_timer: loadable settle down-counter with a zero-count bypass flag
module sp_settle_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_count,
  output logic         o_zero,
  output logic         o_last
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else r_cnt <= i_load ? i_count : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
  end
  assign o_zero = i_count == '0;
  assign o_last = r_cnt <= W'(1);
endmodule

// File: rtl/sp_sweep_sequencer.sv
// sp_sweep_sequencer: DC bias capture followed by a two-port stepped-frequency wave sweep
module sp_sweep_sequencer
  import sp_seq_pkg::*;
#(
  parameter int FREQ_W   = 16,
  parameter int IDX_W    = RES_IDX_W,
  parameter int SETTLE_W = 8,
  parameter int DATA_W   = RES_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [FREQ_W-1:0]   i_cfg_f_start,
  input  logic [FREQ_W-1:0]   i_cfg_f_step,
  input  logic [IDX_W-1:0]    i_cfg_npts,
  input  logic [SETTLE_W-1:0] i_cfg_settle,
  output logic                o_bias_en,
  output logic                o_src_en,
  output logic                o_src_port,
  output logic [FREQ_W-1:0]   o_freq_word,
  output logic                o_meas_req,
  input  logic                i_meas_ack,
  input  logic [DATA_W-1:0]   i_meas_a,
  input  logic [DATA_W-1:0]   i_meas_b,
  output logic [DATA_W-1:0]   o_dc_data,
  output logic                o_dc_valid,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [IDX_W-1:0]    o_res_idx,
  output logic                o_res_port,
  output logic [DATA_W-1:0]   o_res_a,
  output logic [DATA_W-1:0]   o_res_b,
  output logic                o_busy,
  output logic                o_done
);
  state_t              r_state, w_next;
  logic [FREQ_W-1:0]   r_freq, r_f_step;
  logic [IDX_W-1:0]    r_npts;
  logic [SETTLE_W-1:0] r_settle, w_settle_val;
  logic [DATA_W-1:0]   r_dc_data;
  logic                r_dc_valid, w_load, w_zero, w_last, w_last_pt;
  result_t             r_res;
  assign w_settle_val = r_state == S_IDLE ? i_cfg_settle : r_settle;
  assign w_load = r_state == S_IDLE || r_state == S_SET_SRC;
  sp_settle_timer #(.W(SETTLE_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_count (w_settle_val),
    .o_zero  (w_zero),
    .o_last  (w_last)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_last_pt = r_res.port == PORT2 && r_res.idx == r_npts - 1'b1;
    case (r_state)
      S_IDLE:      w_next = i_start ? S_DC_SETTLE : S_IDLE;
      S_DC_SETTLE: w_next = w_last ? S_DC_MEAS : S_DC_SETTLE;
      S_DC_MEAS:   w_next = !i_meas_ack ? S_DC_MEAS : (r_npts == '0 ? S_FIN : S_SET_SRC);
      S_SET_SRC:   w_next = w_zero ? S_MEAS : S_SETTLE;
      S_SETTLE:    w_next = w_last ? S_MEAS : S_SETTLE;
      S_MEAS:      w_next = i_meas_ack ? S_EMIT : S_MEAS;
      S_EMIT:      w_next = i_res_ready ? S_NEXT : S_EMIT;
      S_NEXT:      w_next = w_last_pt ? S_FIN : S_SET_SRC;
      default:     w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
    o_busy      = r_state != S_IDLE;
    o_bias_en   = o_busy && r_state != S_FIN;
    o_src_en    = r_state inside {S_SET_SRC, S_SETTLE, S_MEAS, S_EMIT, S_NEXT};
    o_src_port  = o_src_en & r_res.port;
    o_freq_word = o_src_en ? r_freq : '0;
    o_meas_req  = r_state == S_DC_MEAS || r_state == S_MEAS;
    o_res_valid = r_state == S_EMIT;
    o_res_idx   = o_res_valid ? r_res.idx : '0;
    o_res_port  = o_res_valid & r_res.port;
    o_res_a     = o_res_valid ? r_res.a : '0;
    o_res_b     = o_res_valid ? r_res.b : '0;
    o_done      = r_state == S_FIN;
    o_dc_data   = r_dc_data;
    o_dc_valid  = r_dc_valid;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_freq     <= '0;
      r_f_step   <= '0;
      r_npts     <= '0;
      r_settle   <= '0;
      r_dc_data  <= '0;
      r_dc_valid <= 1'b0;
      r_res      <= '0;
    end else if (i_abort) begin
      r_freq <= '0;
      r_res  <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_freq     <= i_cfg_f_start;
        r_f_step   <= i_cfg_f_step;
        r_npts     <= i_cfg_npts;
        r_settle   <= i_cfg_settle;
        r_dc_valid <= 1'b0;
        r_res      <= '0;
      end
      if (r_state == S_DC_MEAS && i_meas_ack) begin
        r_dc_data  <= i_meas_a;
        r_dc_valid <= 1'b1;
      end
      if (r_state == S_MEAS && i_meas_ack) begin
        r_res.a <= i_meas_a;
        r_res.b <= i_meas_b;
      end
      if (r_state == S_NEXT) begin
        if (r_res.port == PORT1) r_res.port <= PORT2;
        else if (!w_last_pt) begin
          r_res.idx  <= r_res.idx + 1'b1;
          r_res.port <= PORT1;
          r_freq     <= r_freq + r_f_step;
        end
      end
    end
  end
endmodule

// File: doc/sp_sweep_sequencer.md
Name: sp_sweep_sequencer

Overview:
- Sequences a two-port DC + S-parameter characterisation of a balun/filter test fixture.
- Phase 1 applies DC bias, settles, and captures one probe reading.
- Phase 2 steps a frequency sweep. At each point it excites port 1 and then port 2, waits a settle interval, requests a wave measurement, and streams (a, b) results downstream with a valid/ready handshake.
- Sits between the register/config block and the source/receiver datapath (Pac sources, bias Vdc, voltage probe).

Parameters:
- FREQ_W, 16, width of frequency word and step.
- IDX_W, 8, width of point count/index; max 255 points.
- SETTLE_W, 8, width of settle-cycle count.
- DATA_W, 16, width of measured wave samples and DC probe value.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous abort; return to IDLE.
- cfg_f_start  in  FREQ_W  first frequency word.
- cfg_f_step  in  FREQ_W  frequency increment per point.
- cfg_npts  in  IDX_W  number of frequency points.
- cfg_settle  in  SETTLE_W  settle cycles before each measurement.
- bias_en  out  1  DC bias source enable.
- src_en  out  1  AC source enable.
- src_port  out  1  excited port: 0 = port 1, 1 = port 2.
- freq_word  out  FREQ_W  current source frequency.
- meas_req  out  1  measurement request to receiver.
- meas_ack  in  1  receiver acknowledge; data valid this cycle.
- meas_a  in  DATA_W  incident wave or DC probe sample.
- meas_b  in  DATA_W  reflected/transmitted wave sample.
- dc_data  out  DATA_W  captured DC probe value.
- dc_valid  out  1  dc_data valid; stays high until next start.
- res_valid  out  1  sweep result valid.
- res_ready  in  1  downstream ready.
- res_idx  out  IDX_W  frequency index of result.
- res_port  out  1  excited port of result.
- res_a  out  DATA_W  captured a sample.
- res_b  out  DATA_W  captured b sample.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - Abort forces the same output values, except dc_data/dc_valid, which hold.
- Config latch: cfg_* are captured on the start cycle, so later changes have no effect mid-run. start is ignored while busy.
- States: IDLE, DC_SETTLE, DC_MEAS, SET_SRC, SETTLE, MEAS, EMIT, NEXT, FIN.
- IDLE:
  - On start, go to DC_SETTLE next cycle and clear dc_valid.
  - bias_en = 1 from that cycle until FIN or abort.
- DC_SETTLE: count cfg_settle cycles; with cfg_settle = 0, go straight to DC_MEAS.
- DC_MEAS:
  - Hold meas_req high until meas_ack.
  - On the ack cycle, capture meas_a into dc_data; dc_valid = 1 from the next cycle.
  - Then go to FIN if npts = 0, else to SET_SRC with idx = 0, port = 0, freq = f_start.
- SET_SRC: drive src_en = 1, src_port, and freq_word for one cycle, then go to SETTLE.
- SETTLE: same counting rule as DC_SETTLE, then MEAS.
- MEAS: same handshake as DC_MEAS; capture meas_a/meas_b on the ack cycle.
  - meas_req drops the cycle after ack.
  - An ack arriving while req is low is ignored.
- EMIT:
  - res_valid is held with res_* stable until res_ready.
  - The transfer completes on the cycle where res_valid & res_ready; res_valid drops the next cycle.
  - res_ready may be high before valid; there is no combinational ready-to-valid path.
- NEXT:
  - If port = 0: set port = 1 and go to SET_SRC.
  - Else if idx = npts-1: go to FIN.
  - Else: idx+1, port = 0, freq_word += f_step (modulo 2^FREQ_W, wraps silently), go to SET_SRC.
- FIN:
  - Deassert src_en and bias_en, pulse done for one cycle, go to IDLE.
  - busy is low from the cycle after FIN.
- src_en stays 1 from the first SET_SRC through the last EMIT; it is dropped in FIN or on abort.
- Abort has priority over all transitions, including a simultaneous meas_ack or res_ready. No done pulse and no partial result are emitted.
- Output counts:
  - Results per run: exactly 2·npts, ordered (idx 0, p0), (idx 0, p1), (idx 1, p0), …
  - Minimum cycles per result with ack/ready immediate: 4 + settle.

Decomposition:
- Shared package sp_seq_pkg holds:
  - the state enum;
  - the PORT1/PORT2 constants;
  - a result struct {idx, port, a, b}.
- One sub-module, sp_settle_timer:
  - load/count-down with a zero-count bypass;
  - reused by DC_SETTLE and SETTLE.

Test Plan:
- DC-only run: npts = 0, settle = 3, ack after 2 cycles, meas_a = 0x1234.
  - dc_data = 0x1234 and dc_valid high.
  - Zero results; done pulses once.
  - bias_en is high for exactly the DC phase.
- Basic sweep: f_start = 0x0100, step = 0x0010, npts = 3, settle = 0, ack/ready immediate.
  - Six results with (idx, port) = (0,0), (0,1), (1,0), (1,1), (2,0), (2,1).
  - freq_word = 0x0100, 0x0110, 0x0120.
- Backpressure: res_ready low for 5 cycles during the first EMIT.
  - res_valid and res_* held stable.
  - No meas_req issued until the transfer completes.
- Wrap: f_start = 0xFFF0, step = 0x0020, npts = 2.
  - Second freq_word = 0x0010; no error.
- Abort during second MEAS with meas_ack asserted the same cycle.
  - Next cycle: IDLE, src_en = bias_en = 0, no res_valid, no done, dc_valid retained.
- Reset mid-EMIT, then start again with new config.
  - All outputs are 0 during reset.
  - The new run uses only the new cfg values; start pulses while busy are ignored.
